// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin two-master Avalon-MM arbiter for the SDRAM controller slave port
module sdram_port_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 4
) (
  input  logic                sys_ref_clk_clk,
  input  logic                sys_ref_reset_reset,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,

  output logic                rd_err
);

  localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             prio;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             id_mem [MAX_PEND];

  logic room;
  logic elig0;
  logic elig1;
  logic gnt0;
  logic gnt1;
  logic accept;
  logic push;
  logic pop;
  logic head_id;

  // Reads need a free ID slot; writes never wait on the FIFO.
  assign room  = count < CNT_W'(MAX_PEND);
  assign elig0 = m0_write | (m0_read & room);
  assign elig1 = m1_write | (m1_read & room);

  assign gnt0 = (state == ST_GNT0);
  assign gnt1 = (state == ST_GNT1);

  always_comb begin
    s_address    = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_writedata  = '0;
    s_byteenable = '0;
    if (gnt0) begin
      s_address    = m0_address;
      s_read       = m0_read;
      s_write      = m0_write;
      s_writedata  = m0_writedata;
      s_byteenable = m0_byteenable;
    end else if (gnt1) begin
      s_address    = m1_address;
      s_read       = m1_read;
      s_write      = m1_write;
      s_writedata  = m1_writedata;
      s_byteenable = m1_byteenable;
    end
  end

  assign m0_waitrequest = gnt0 ? s_waitrequest : 1'b1;
  assign m1_waitrequest = gnt1 ? s_waitrequest : 1'b1;

  assign accept = (s_read | s_write) & ~s_waitrequest;
  assign push   = accept & s_read;
  assign pop    = s_readdatavalid & (count != '0);

  // Returns come back in issue order, so the FIFO head names the owner.
  assign head_id          = id_mem[head];
  assign m0_readdatavalid = pop & ~head_id;
  assign m1_readdatavalid = pop & head_id;
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (elig0 && elig1) begin
          state_nxt = prio ? ST_GNT1 : ST_GNT0;
        end else if (elig0) begin
          state_nxt = ST_GNT0;
        end else if (elig1) begin
          state_nxt = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (accept || !(m0_read || m0_write)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (accept || !(m1_read || m1_write)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_ref_clk_clk) begin
    if (sys_ref_reset_reset) begin
      state  <= ST_IDLE;
      prio   <= 1'b0;
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      rd_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        prio <= gnt0;
      end
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (s_readdatavalid && (count == '0)) begin
        rd_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_ref_clk_clk) begin
    if (push) begin
      id_mem[tail] <= gnt1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed and randomized checks of sdram_port_arbiter against a transaction-level model
module tb_sdram_port_arbiter;

  localparam int AW   = 25;
  localparam int DW   = 16;
  localparam int BW   = 2;
  localparam int MP   = 4;
  localparam int RCYC = 500;
  localparam int DCYC = 120;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic          m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [BW-1:0] m0_byteenable, m1_byteenable, s_byteenable;
  logic          m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
  logic          m0_readdatavalid, m1_readdatavalid, s_readdatavalid;
  logic          rd_err;

  int checks = 0;
  int errors = 0;

  // Transaction model: pending master commands and the queue of read owners.
  bit            pend [2];
  bit            is_rd [2];
  logic [AW-1:0] c_addr [2];
  logic [DW-1:0] c_data [2];
  logic [BW-1:0] c_be [2];
  bit            acc [2];
  bit            waited [2];
  bit            oq [$];
  bit            front;
  bit            g;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PEND(MP)) dut (
    .sys_ref_clk_clk(clk), .sys_ref_reset_reset(rst),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .rd_err(rd_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals();
    smp();
    chk("rst_slave_cmd", 64'({s_read, s_write}), 64'(0));
    chk("rst_slave_fields", 64'({s_address, s_writedata, s_byteenable}), 64'(0));
    chk("rst_waitreq", 64'({m0_waitrequest, m1_waitrequest}), 64'(2'b11));
    chk("rst_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
    chk("rst_rd_err", 64'(rd_err), 64'(0));
    chk("rst_count", 64'(dut.count), 64'(0));
    chk("rst_prio", 64'(dut.prio), 64'(0));
    tick();
  endtask

  task automatic issue(input bit m, input bit rd, input logic [AW-1:0] a);
    bit done;
    done = 1'b0;
    if (m) begin
      m1_read = rd; m1_write = !rd; m1_address = a;
    end else begin
      m0_read = rd; m0_write = !rd; m0_address = a;
    end
    for (int k = 0; k < 10 && !done; k++) begin
      smp();
      if ((m ? m1_waitrequest : m0_waitrequest) == 1'b0) done = 1'b1;
      tick();
    end
    if (m) begin
      m1_read = 1'b0; m1_write = 1'b0;
    end else begin
      m0_read = 1'b0; m0_write = 1'b0;
    end
    chk("issue_accepted", 64'(done), 64'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clr_inputs();
    tick();
    tick();
    rst = 1'b0;
    chk_reset_vals();

    // Single write from m0.
    m0_write = 1'b1; m0_address = 25'h0000123; m0_writedata = 16'hBEEF; m0_byteenable = 2'b11;
    smp(); chk("t1_req_cycle", 64'(s_write), 64'(0)); tick();
    smp();
    chk("t1_s_write", 64'({s_write, s_read}), 64'(2'b10));
    chk("t1_fields", 64'({s_address, s_writedata, s_byteenable}), 64'({25'h0000123, 16'hBEEF, 2'b11}));
    chk("t1_waitreq", 64'({m0_waitrequest, m1_waitrequest}), 64'(2'b01));
    tick();
    m0_write = 1'b0;
    smp();
    chk("t1_single_cycle", 64'(s_write), 64'(0));
    chk("t1_prio", 64'(dut.prio), 64'(1));
    tick();

    // Alternating writes from both masters.
    do_reset();
    m0_write = 1'b1; m0_address = 25'h10; m0_writedata = 16'h1111; m0_byteenable = 2'b11;
    m1_write = 1'b1; m1_address = 25'h20; m1_writedata = 16'h2222; m1_byteenable = 2'b11;
    for (int k = 0; k < 8; k++) begin
      logic [25:0] e;
      e = (k % 2 == 1) ? {1'b1, ((k % 4 == 1) ? 25'h10 : 25'h20)} : 26'd0;
      smp();
      chk("t2_grant", 64'({s_write, s_address}), 64'(e));
      tick();
    end
    clr_inputs();

    // Held grant under s_waitrequest.
    do_reset();
    s_waitrequest = 1'b1; m1_read = 1'b1; m1_address = 25'h55;
    smp(); chk("t3_idle", 64'(s_read), 64'(0)); tick();
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("t3_held", 64'({s_read, s_address, m0_waitrequest, m1_waitrequest}), 64'({1'b1, 25'h55, 1'b1, 1'b1}));
      tick();
    end
    s_waitrequest = 1'b0;
    smp(); chk("t3_accept", 64'({s_read, m0_waitrequest, m1_waitrequest}), 64'(3'b110)); tick();
    m1_read = 1'b0;
    s_readdatavalid = 1'b1; s_readdata = 16'hAAAA;
    smp();
    chk("t3_count_one", 64'(dut.count), 64'(1));
    chk("t3_return", 64'({m0_readdatavalid, m1_readdatavalid, m1_readdata}), 64'({2'b01, 16'hAAAA}));
    tick();
    s_readdatavalid = 1'b0;

    // Interleaved reads m0, m1, m0.
    issue(1'b0, 1'b1, 25'h100);
    issue(1'b1, 1'b1, 25'h101);
    issue(1'b0, 1'b1, 25'h102);
    smp(); chk("t4_count_three", 64'(dut.count), 64'(3)); tick();
    for (int k = 0; k < 3; k++) begin
      s_readdatavalid = 1'b1; s_readdata = 16'(k + 1);
      smp();
      chk("t4_route", 64'({m0_readdatavalid, m1_readdatavalid}), 64'((k == 1) ? 2'b01 : 2'b10));
      chk("t4_data", 64'((k == 1) ? m1_readdata : m0_readdata), 64'(k + 1));
      tick();
    end
    s_readdatavalid = 1'b0;
    smp(); chk("t4_count_zero", 64'(dut.count), 64'(0)); tick();

    // FIFO full: fifth read waits, concurrent write proceeds.
    for (int k = 0; k < 4; k++) issue(1'b0, 1'b1, AW'(32'h200 + k));
    m0_read = 1'b1; m0_address = 25'h300;
    m1_write = 1'b1; m1_address = 25'h301; m1_writedata = 16'h5A5A; m1_byteenable = 2'b01;
    smp(); chk("t5_full_count", 64'(dut.count), 64'(MP)); tick();
    smp(); chk("t5_write_through", 64'({s_write, s_read, s_address}), 64'({2'b10, 25'h301})); tick();
    m1_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp(); chk("t5_read_blocked", 64'({s_read, m0_waitrequest}), 64'(2'b01)); tick();
    end
    s_readdatavalid = 1'b1; s_readdata = 16'h0BAD;
    smp(); chk("t5_pop", 64'({s_read, m0_readdatavalid, m1_readdatavalid}), 64'(3'b010)); tick();
    s_readdatavalid = 1'b0;
    smp(); chk("t5_grant_cycle", 64'({s_read, dut.count}), 64'({1'b0, 3'd3})); tick();
    smp(); chk("t5_read_issued", 64'({s_read, s_address, m0_waitrequest}), 64'({1'b1, 25'h300, 1'b0})); tick();
    m0_read = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_readdatavalid = 1'b1; s_readdata = 16'(k);
      smp(); chk("t5_drain", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(2'b10)); tick();
    end
    s_readdatavalid = 1'b0;
    smp(); chk("t5_count_zero", 64'(dut.count), 64'(0)); tick();

    // Reset with a read outstanding, then an unmatched return.
    issue(1'b1, 1'b1, 25'h400);
    do_reset();
    s_readdatavalid = 1'b1; s_readdata = 16'h7777;
    smp();
    chk("t6_reset_count", 64'(dut.count), 64'(0));
    chk("t6_unmatched_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
    tick();
    s_readdatavalid = 1'b0;
    smp(); chk("t6_rd_err_set", 64'(rd_err), 64'(1)); tick();
    do_reset();
    chk_reset_vals();

    // Randomized traffic checked against the transaction model.
    do_reset();
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; acc[m] = 1'b0; waited[m] = 1'b0; is_rd[m] = 1'b0;
      c_addr[m] = '0; c_data[m] = '0; c_be[m] = '0;
    end
    oq.delete();
    for (int cyc = 0; cyc < RCYC + DCYC; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (acc[m]) pend[m] = 1'b0;
        if (!pend[m] && cyc < RCYC && $urandom_range(0, 1) == 1) begin
          pend[m]   = 1'b1;
          is_rd[m]  = 1'($urandom);
          c_addr[m] = AW'($urandom);
          c_data[m] = DW'($urandom);
          c_be[m]   = BW'($urandom);
        end
      end
      m0_read = pend[0] && is_rd[0]; m0_write = pend[0] && !is_rd[0];
      m0_address = c_addr[0]; m0_writedata = c_data[0]; m0_byteenable = c_be[0];
      m1_read = pend[1] && is_rd[1]; m1_write = pend[1] && !is_rd[1];
      m1_address = c_addr[1]; m1_writedata = c_data[1]; m1_byteenable = c_be[1];
      s_waitrequest = ($urandom_range(0, 3) == 0);
      s_readdatavalid = (oq.size() != 0) && ($urandom_range(0, 2) == 0);
      s_readdata = DW'($urandom);
      smp();
      chk("rnd_count", 64'(dut.count), 64'(oq.size()));
      if (s_readdatavalid) begin
        front = oq.pop_front();
        chk("rnd_rdv_route", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(front ? 2'b01 : 2'b10));
        chk("rnd_rdata", 64'({m0_readdata, m1_readdata}), 64'({s_readdata, s_readdata}));
      end else begin
        chk("rnd_rdv_idle", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
      end
      acc[0] = 1'b0; acc[1] = 1'b0;
      if (!(s_read || s_write) || s_waitrequest) begin
        chk("rnd_wait_held", 64'({m0_waitrequest, m1_waitrequest}), 64'(2'b11));
      end else begin
        g = m0_waitrequest;
        chk("rnd_one_grant", 64'({m0_waitrequest, m1_waitrequest}), 64'(g ? 2'b10 : 2'b01));
        chk("rnd_fields", 64'({s_read, s_write, s_address, s_writedata, s_byteenable}),
            64'({pend[g] && is_rd[g], pend[g] && !is_rd[g], c_addr[g], c_data[g], c_be[g]}));
        chk("rnd_fair", 64'(waited[!g]), 64'(0));
        if (is_rd[g]) chk("rnd_fifo_room", 64'(oq.size() < MP), 64'(1));
        waited[g]  = 1'b0;
        waited[!g] = pend[!g] && !is_rd[!g];
        acc[g] = 1'b1;
        if (is_rd[g]) oq.push_back(g);
      end
      tick();
    end
    clr_inputs();
    smp();
    chk("end_count", 64'(dut.count), 64'(0));
    chk("end_rd_err", 64'(rd_err), 64'(0));
    chk("end_idle", 64'({s_read, s_write}), 64'(0));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-master, one-slave Avalon-MM arbiter that shares the SDR SDRAM controller's 16-bit slave port between two requesters, such as a pushbutton-driven pattern writer and a hex/LED display reader. Arbitration is round-robin, one transaction per grant. Reads are pipelined, so the owner of each outstanding read is tracked in an ID FIFO, and each returned `readdatavalid` is routed to the master that issued it. The block sits between the custom masters and the SDRAM controller slave inside the system, on the SDRAM clock domain.

## Interface
- `ADDR_W`, 25: word address width (13 row + 10 col + 2 bank).
- `DATA_W`, 16: data width; byteenable width is `DATA_W/8`.
- `MAX_PEND`, 4: maximum outstanding reads (ID FIFO depth), power of two, 2..16.

- `sys_ref_clk_clk`, in, 1: single clock; all logic is on its rising edge.
- `sys_ref_reset_reset`, in, 1: synchronous, active-high reset.
- `m0_address` / `m1_address`, in, `ADDR_W`: master word address.
- `m0_read`, `m0_write` / `m1_read`, `m1_write`, in, 1 each: command strobes, mutually exclusive per master.
- `m0_writedata` / `m1_writedata`, in, `DATA_W`: write data.
- `m0_byteenable` / `m1_byteenable`, in, `DATA_W/8`: byte enables.
- `m0_waitrequest` / `m1_waitrequest`, out, 1: command stall.
- `m0_readdata` / `m1_readdata`, out, `DATA_W`: read return data.
- `m0_readdatavalid` / `m1_readdatavalid`, out, 1: read return strobe.
- `s_address`, out, `ADDR_W`: slave-side address.
- `s_read`, `s_write`, out, 1 each: slave-side command strobes.
- `s_writedata`, out, `DATA_W`: slave-side write data.
- `s_byteenable`, out, `DATA_W/8`: slave-side byte enables.
- `s_waitrequest`, in, 1: slave command stall.
- `s_readdata`, in, `DATA_W`: slave read data.
- `s_readdatavalid`, in, 1: slave read return strobe.
- `rd_err`, out, 1: sticky flag for a `readdatavalid` that arrives with no read outstanding; cleared only by reset.

## Operation
- State machine has three states: IDLE, GNT0, GNT1. A priority pointer `prio` (0 or 1) records the preferred master.
- Eligibility:
  - A master with `write` asserted is eligible.
  - A master with `read` asserted is eligible only if `count < MAX_PEND`.
- IDLE:
  - If both masters are eligible, go to GNT`prio`.
  - If one is eligible, go to its GNT state.
  - If none is eligible, stay in IDLE.
- GNTx:
  - Slave outputs mux master x's address, read, write, writedata and byteenable.
  - `mx_waitrequest = s_waitrequest`. The other master's waitrequest is held at 1.
- Acceptance is the cycle in GNTx where (`s_read` or `s_write`) and `!s_waitrequest`. On acceptance:
  - Next state is IDLE.
  - `prio` becomes the other master.
  - If the accepted command was a read, push ID x into the FIFO.
- If master x drops both strobes while in GNTx (a protocol violation), return to IDLE. `prio` is unchanged and nothing is pushed.
- Outside GNTx, `s_read = s_write = 0`, `s_address`/`s_writedata` are don't-care (the implementation drives them to 0), and both waitrequests are 1.
- Read return:
  - `m0_readdata = m1_readdata = s_readdata`, combinational broadcast.
  - `mx_readdatavalid = s_readdatavalid && count != 0 && head == x`.
  - Each `s_readdatavalid` with `count != 0` pops the FIFO.
- `s_readdatavalid` with `count == 0` is dropped: no master strobe, and `rd_err` is set.
- Push and pop in the same cycle leave `count` unchanged. Head and tail pointers wrap modulo `MAX_PEND`. `count` has `log2(MAX_PEND)+1` bits.

## Timing
- Reset values:
  - State IDLE, `prio` = 0, `count` = 0, pointers 0, `rd_err` = 0.
  - `s_read` = `s_write` = 0, `s_address` = `s_writedata` = `s_byteenable` = 0.
  - `m0_waitrequest` = `m1_waitrequest` = 1, `m0_readdatavalid` = `m1_readdatavalid` = 0.
- Grant latency:
  - A request seen in IDLE at edge N drives the slave in cycle N+1.
  - With `s_waitrequest` = 0, acceptance occurs at edge N+1 and the state is IDLE at N+2.
  - Peak throughput is one command per 2 cycles.
- Read return adds 0 cycles: master `readdatavalid`/`readdata` are combinational from the slave in the same cycle.
- A full FIFO blocks new read grants from the cycle `count` reaches `MAX_PEND` until the cycle after a pop. Writes are never blocked by the FIFO.
- Reset mid-operation empties the FIFO and drops any grant. Returns that arrive after reset are treated as unmatched and set `rd_err`.

## Test plan
- **Single write.** After reset, m0 writes addr 0x0000123, data 0xBEEF, be 2'b11, with `s_waitrequest` = 0. Required: `s_write` high for exactly 1 cycle, one cycle after the request, with matching fields. `m0_waitrequest` is low in that cycle. `prio` becomes 1.
- **Alternating writes.** Both masters request writes continuously. Required: slave grants alternate m0, m1, m0, m1 (m0 first after reset), one accept every 2 cycles.
- **Held grant.** m1 reads while `s_waitrequest` is held high for 3 cycles. Required: grant stays GNT1 with stable slave signals and `m0_waitrequest` = 1. Accept occurs on the 4th cycle.
- **Interleaved read returns.** Interleaved reads m0, m1, m0 are answered by `s_readdatavalid` with data 0x0001, 0x0002, 0x0003. Required: `readdatavalid` goes to m0, m1, m0 respectively, and `count` returns to 0.
- **FIFO full.** With `MAX_PEND` = 4 and 4 reads outstanding, a 5th read is not granted. A concurrent write from the other master is granted. The read is granted in the cycle after the first pop.
- **Unmatched return and reset.** Pulse `s_readdatavalid` with `count` = 0. Required: no master strobe and `rd_err` = 1. Asserting `sys_ref_reset_reset` for 1 cycle clears it and restores all reset values.
